// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - I2C target for 3-byte codec writes ({DEV_ADDR,W}, {addr,d[8]}, d[7:0])
// Synchronizes raw SCL/SDA, decodes START/STOP/bits, ACKs matching writes and commits them to a 9-bit register file.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 10,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sdat_oe,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_busy,
  output logic       o_err,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  state_t     state, state_n;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic       scl_rise, scl_fall, start, stop;
  logic [2:0] cnt, cnt_n;
  logic [6:0] shift, shift_n;
  logic [7:0] byte1, byte1_n;
  logic [7:0] in_byte;
  logic       ack_low, ack_low_n;
  logic       commit;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [8:0] regs [NUM_REGS];
  logic [8:0] rd_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {i_sclk, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {i_sdat, sda_s1, sda_s2};
    end
  end

  // Requiring SCL high in both samples drops any cycle where SCL and SDA toggle together.
  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start    = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop     = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign in_byte  = {shift, sda_s2};
  assign wr_addr  = byte1[7:1];
  assign wr_data  = {byte1[0], in_byte};

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shift_n   = shift;
    byte1_n   = byte1;
    ack_low_n = ack_low;
    commit    = 1'b0;
    case (state)
      ADDR, BYTE1, BYTE2: begin
        if (scl_rise) begin
          shift_n = in_byte[6:0];
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            ack_low_n = 1'b0;
            case (state)
              ADDR:    state_n = (in_byte == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
              BYTE1: begin
                byte1_n = in_byte;
                state_n = ACK_1;
              end
              default: begin
                commit  = 1'b1;
                state_n = ACK_2;
              end
            endcase
          end
        end
      end
      ACK_A, ACK_1, ACK_2: begin
        // First fall after bit 8 pulls SDA low; the fall ending the 9th clock releases it.
        if (scl_fall) begin
          if (!ack_low) begin
            ack_low_n = 1'b1;
          end else begin
            ack_low_n = 1'b0;
            cnt_n     = 3'd0;
            case (state)
              ACK_A:   state_n = BYTE1;
              ACK_1:   state_n = BYTE2;
              default: state_n = IGNORE;
            endcase
          end
        end
      end
      default: ;
    endcase
    if (stop) begin
      state_n   = IDLE;
      ack_low_n = 1'b0;
    end else if (start) begin
      state_n   = ADDR;
      cnt_n     = 3'd0;
      ack_low_n = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      shift      <= 7'd0;
      byte1      <= 8'd0;
      ack_low    <= 1'b0;
      o_sdat_oe  <= 1'b0;
      o_wr_valid <= 1'b0;
      o_err      <= 1'b0;
      o_busy     <= 1'b0;
      o_wr_addr  <= 7'd0;
      o_wr_data  <= 9'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shift      <= shift_n;
      byte1      <= byte1_n;
      ack_low    <= ack_low_n;
      o_sdat_oe  <= ack_low;
      o_wr_valid <= commit;
      o_err      <= commit && (wr_addr >= 7'(NUM_REGS)) && (wr_addr != RESET_REG);
      if (start) o_busy <= 1'b1;
      else if (stop) o_busy <= 1'b0;
      if (commit) begin
        o_wr_addr <= wr_addr;
        o_wr_data <= wr_data;
        if (wr_addr == RESET_REG) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
        end else begin
          for (int i = 0; i < NUM_REGS; i++)
            if (wr_addr == 7'(i)) regs[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = 9'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (i_rd_addr == 4'(i)) rd_data = regs[i];
  end

  assign o_rd_data = rd_data;
  assign o_state   = state;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - scoreboard bench for i2c_codec_responder
// Stimulus drives an I2C initiator and queues expected commits; a monitor pops them on o_wr_valid.
module tb_i2c_codec_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       msda;
  logic       bus_sda;
  logic       sdat_oe;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] a;
    logic [8:0] d;
    logic       e;
    logic [8:0] rd;
  } exp_t;

  exp_t       sb[$];
  exp_t       got;
  logic [8:0] mregs [16];

  assign bus_sda = msda & ~sdat_oe;

  i2c_codec_responder dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sclk     (scl),
    .i_sdat     (bus_sda),
    .o_sdat_oe  (sdat_oe),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_busy     (busy),
    .o_err      (err),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    msda = 1'b0; wait_cyc(10);
    scl  = 1'b0; wait_cyc(5);
  endtask

  task automatic rstart_cond();
    msda = 1'b1; wait_cyc(5);
    scl  = 1'b1; wait_cyc(10);
    msda = 1'b0; wait_cyc(10);
    scl  = 1'b0; wait_cyc(5);
  endtask

  task automatic stop_cond();
    msda = 1'b0; wait_cyc(5);
    scl  = 1'b1; wait_cyc(10);
    msda = 1'b1; wait_cyc(10);
  endtask

  task automatic send_bit(input logic b);
    msda = b;    wait_cyc(5);
    scl  = 1'b1; wait_cyc(10);
    scl  = 1'b0; wait_cyc(5);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack_exp);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    msda = 1'b1; wait_cyc(5);
    scl  = 1'b1; wait_cyc(5);
    a = bus_sda; wait_cyc(5);
    scl  = 1'b0; wait_cyc(5);
    check($sformatf("ack_%02h", b), {15'd0, a}, {15'd0, ack_exp});
  endtask

  task automatic expect_write(input logic [6:0] a, input logic [8:0] d, input logic [3:0] rda);
    exp_t e;
    if (a == 7'h0F) begin
      for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
    end else if (a < 7'd10) begin
      mregs[a[3:0]] = d;
    end
    rd_addr = rda;
    e.a  = a;
    e.d  = d;
    e.e  = (a >= 7'd10) && (a != 7'h0F);
    e.rd = mregs[rda];
    sb.push_back(e);
  endtask

  task automatic txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic ack_exp);
    start_cond();
    check("busy_start", {15'd0, busy}, 16'd1);
    send_byte(b0, ack_exp);
    send_byte(b1, ack_exp);
    send_byte(b2, ack_exp);
    stop_cond();
  endtask

  task automatic end_checks();
    check("busy_stop", {15'd0, busy}, 16'd0);
    check("state_idle", {13'd0, state}, 16'd0);
    check("pending", 16'(sb.size()), 16'd0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      wait_cyc(1);
      check($sformatf("rd_%0d", a), {7'd0, rd_data}, {7'd0, mregs[a]});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected got addr %0h data %0h expected no write", wr_addr, wr_data);
        end else begin
          got = sb.pop_front();
          check("wr_addr", {9'd0, wr_addr}, {9'd0, got.a});
          check("wr_data", {7'd0, wr_data}, {7'd0, got.d});
          check("wr_err", {15'd0, err}, {15'd0, got.e});
          check("rd_on_commit", {7'd0, rd_data}, {7'd0, got.rd});
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_alone got 1 expected 0");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
    rst = 1'b1; scl = 1'b1; msda = 1'b1; rd_addr = 4'd0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);
    check("rst_state", {13'd0, state}, 16'd0);
    check("rst_oe", {15'd0, sdat_oe}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_wr_addr", {9'd0, wr_addr}, 16'd0);
    check("rst_wr_data", {7'd0, wr_data}, 16'd0);
    read_all();

    // reg 7 = 0x042
    expect_write(7'd7, 9'h042, 4'd7);
    txn(8'h34, 8'h0E, 8'h42, 1'b0);
    end_checks();

    // reg 4 = 0x1FF, then a 4th byte that must be NACKed
    expect_write(7'd4, 9'h1FF, 4'd4);
    start_cond();
    send_byte(8'h34, 1'b0);
    send_byte(8'h09, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b1);
    stop_cond();
    end_checks();
    read_all();

    // wrong device address: no ACKs, no write
    txn(8'h36, 8'h0E, 8'h42, 1'b1);
    end_checks();
    read_all();

    // unsupported address 0x0C, then RESET_REG
    expect_write(7'h0C, 9'h055, 4'd12);
    txn(8'h34, 8'h18, 8'h55, 1'b0);
    end_checks();
    read_all();
    expect_write(7'h0F, 9'h000, 4'd7);
    txn(8'h34, 8'h1E, 8'h00, 1'b0);
    end_checks();
    read_all();

    // repeated START after byte1 discards it; then reg 2 = 0x017
    expect_write(7'd2, 9'h017, 4'd2);
    start_cond();
    send_byte(8'h34, 1'b0);
    send_byte(8'h0C, 1'b0);
    rstart_cond();
    send_byte(8'h34, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h17, 1'b0);
    stop_cond();
    end_checks();
    read_all();

    // reset while ACK_1 is pulling SDA low
    start_cond();
    send_byte(8'h34, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(8'h0E >> i);
    msda = 1'b1; wait_cyc(5);
    check("ack1_oe", {15'd0, sdat_oe}, 16'd1);
    check("ack1_state", {13'd0, state}, 16'd4);
    rst = 1'b1;
    wait_cyc(1);
    check("rst_mid_oe", {15'd0, sdat_oe}, 16'd0);
    check("rst_mid_state", {13'd0, state}, 16'd0);
    check("rst_mid_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
    check("rst_mid_wr_addr", {9'd0, wr_addr}, 16'd0);
    check("rst_mid_wr_data", {7'd0, wr_data}, 16'd0);
    read_all();
    scl = 1'b1; wait_cyc(10);
    scl = 1'b0; wait_cyc(5);
    stop_cond();
    wait_cyc(5);
    end_checks();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
